game_flow_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 26 ++
 rtl/frame_delay_cnt.sv | 28 ++
 rtl/game_flow_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow slice.
// State codes double as the HUD/debug state_code values.
package pong_pkg;

    localparam int SCORE_W = 8;
    localparam int TOTAL_W = 16;

    localparam logic [2:0] CODE_IDLE      = 3'd0;
    localparam logic [2:0] CODE_SERVE     = 3'd1;
    localparam logic [2:0] CODE_PLAY      = 3'd2;
    localparam logic [2:0] CODE_LEVEL_UP  = 3'd3;
    localparam logic [2:0] CODE_GAME_OVER = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = CODE_IDLE,
        SERVE     = CODE_SERVE,
        PLAY      = CODE_PLAY,
        LEVEL_UP  = CODE_LEVEL_UP,
        GAME_OVER = CODE_GAME_OVER
    } game_state_t;

    function automatic logic [TOTAL_W-1:0] sat_inc_total(input logic [TOTAL_W-1:0] v);
        return (v == {TOTAL_W{1'b1}}) ? v : v + TOTAL_W'(1);
    endfunction

endpackage

// File: rtl/frame_delay_cnt.sv
// Loadable frame down-counter used for the SERVE and LEVEL_UP holds.
// Load wins over enable; counting stops at zero; o_zero is combinational from the count.
module frame_delay_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             frame_clk,
    input  logic             level_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge frame_clk or posedge level_rst) begin
        if (level_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM behind the collision stage: lives, levels, score and serve/game-over sequencing.
// All outputs registered, 1 frame_clk latency; GAME_FLOW_EXTRA_LIFE_EN adds a hit-rally extra life.
module game_flow_ctrl
    import pong_pkg::*;
#(
    parameter int START_LIVES     = 3,
    parameter int LIVES_W         = 3,
    parameter int SCORE_PER_LEVEL = 5,
    parameter int MAX_LEVEL       = 4,
    parameter int SERVE_FRAMES    = 90,
    parameter int LEVEL_FRAMES    = 120,
    parameter int CNT_W           = 8
) (
    input  logic               frame_clk,
    input  logic               level_rst,
    input  logic               start_btn,
    input  logic               hit,
    input  logic               miss,
    input  logic [SCORE_W-1:0] score,
    output logic               pause,
    output logic [7:0]         lvl_num,
    output logic [LIVES_W-1:0] lives,
    output logic [TOTAL_W-1:0] total_score,
    output logic               serve,
    output logic               game_over,
    output logic [2:0]         state_code
);

    localparam logic [LIVES_W-1:0] START_LV  = LIVES_W'(START_LIVES);
    localparam logic [SCORE_W-1:0] SCORE_THR = SCORE_W'(SCORE_PER_LEVEL);
    localparam logic [7:0]         MAX_LVL   = 8'(MAX_LEVEL);
    localparam logic [CNT_W-1:0]   SERVE_LD  = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   LEVEL_LD  = CNT_W'(LEVEL_FRAMES - 1);

    game_state_t        r_state, w_next_state;
    logic               r_pause, r_serve, r_game_over;
    logic [7:0]         r_lvl, w_lvl_d;
    logic [LIVES_W-1:0] r_lives, w_lives_d;
    logic [TOTAL_W-1:0] r_total, w_total_d;
    logic               r_start_prev, r_miss_prev;
    logic [SCORE_W-1:0] r_score_prev;
    logic               w_start_rise, w_miss_rise, w_cnt_zero, w_cnt_en;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_serve_d, w_pause_d, w_game_over_d;

    assign w_start_rise = start_btn & ~r_start_prev;
    assign w_miss_rise  = miss & ~r_miss_prev;
    assign w_cnt_en     = (r_state == SERVE) || (r_state == LEVEL_UP);

    frame_delay_cnt #(.CNT_W(CNT_W)) u_delay (
        .frame_clk (frame_clk),
        .level_rst (level_rst),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .i_en      (w_cnt_en),
        .o_zero    (w_cnt_zero)
    );

    always_ff @(posedge frame_clk or posedge level_rst) begin
        if (level_rst) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    // A miss outranks the level threshold when both land on the same frame.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, GAME_OVER: if (w_start_rise) w_next_state = SERVE;
            SERVE:           if (w_cnt_zero)   w_next_state = PLAY;
            PLAY: begin
                if (w_miss_rise)
                    w_next_state = (r_lives == LIVES_W'(1)) ? GAME_OVER : SERVE;
                else if (score >= SCORE_THR)
                    w_next_state = LEVEL_UP;
            end
            LEVEL_UP:        if (w_cnt_zero)   w_next_state = SERVE;
            default:         w_next_state = IDLE;
        endcase
    end

`ifdef GAME_FLOW_EXTRA_LIFE_EN
    localparam logic [7:0] RALLY_LAST = 8'd19;
    logic       r_hit_prev;
    logic [7:0] r_rally, w_rally_d;
    logic       w_hit_rise;
    assign w_hit_rise = hit & ~r_hit_prev;

    always_ff @(posedge frame_clk or posedge level_rst) begin
        if (level_rst) begin
            r_hit_prev <= 1'b0;
            r_rally    <= '0;
        end else begin
            r_hit_prev <= hit;
            r_rally    <= w_rally_d;
        end
    end
`else
    logic w_unused_hit;
    assign w_unused_hit = hit;
`endif

    always_comb begin
        w_lives_d     = r_lives;
        w_lvl_d       = r_lvl;
        w_total_d     = r_total;
        w_load        = 1'b0;
        w_load_val    = SERVE_LD;
        w_serve_d     = (r_state == SERVE) && w_cnt_zero;
        w_pause_d     = (w_next_state != PLAY);
        w_game_over_d = (w_next_state == GAME_OVER);
        case (r_state)
            IDLE, GAME_OVER: begin
                if (w_start_rise) begin
                    w_lives_d = START_LV;
                    w_lvl_d   = 8'd1;
                    w_total_d = '0;
                    w_load    = 1'b1;
                end
            end
            PLAY: begin
                if (score == r_score_prev + SCORE_W'(1))
                    w_total_d = sat_inc_total(r_total);
                if (w_miss_rise) begin
                    w_lives_d = r_lives - LIVES_W'(1);
                    w_load    = (r_lives != LIVES_W'(1));
                end else if (score >= SCORE_THR) begin
                    w_load     = 1'b1;
                    w_load_val = LEVEL_LD;
                end
            end
            LEVEL_UP: begin
                if (w_cnt_zero) begin
                    w_lvl_d = (r_lvl >= MAX_LVL) ? MAX_LVL : r_lvl + 8'd1;
                    w_load  = 1'b1;
                end
            end
            default: ;
        endcase
`ifdef GAME_FLOW_EXTRA_LIFE_EN
        w_rally_d = r_rally;
        if ((r_state == PLAY) && w_hit_rise) begin
            if (r_rally == RALLY_LAST) begin
                w_rally_d = '0;
                if (!w_miss_rise && (r_lives != {LIVES_W{1'b1}}))
                    w_lives_d = r_lives + LIVES_W'(1);
            end else begin
                w_rally_d = r_rally + 8'd1;
            end
        end
        if ((w_next_state == SERVE) && (r_state != SERVE))
            w_rally_d = '0;
`endif
    end

    // score_prev is held at zero while paused so the first PLAY frame compares against 0.
    always_ff @(posedge frame_clk or posedge level_rst) begin
        if (level_rst) begin
            r_pause      <= 1'b1;
            r_lvl        <= 8'd1;
            r_lives      <= START_LV;
            r_total      <= '0;
            r_serve      <= 1'b0;
            r_game_over  <= 1'b0;
            r_start_prev <= 1'b0;
            r_miss_prev  <= 1'b0;
            r_score_prev <= '0;
        end else begin
            r_pause      <= w_pause_d;
            r_lvl        <= w_lvl_d;
            r_lives      <= w_lives_d;
            r_total      <= w_total_d;
            r_serve      <= w_serve_d;
            r_game_over  <= w_game_over_d;
            r_start_prev <= start_btn;
            r_miss_prev  <= miss;
            r_score_prev <= r_pause ? '0 : score;
        end
    end

    assign pause       = r_pause;
    assign lvl_num     = r_lvl;
    assign lives       = r_lives;
    assign total_score = r_total;
    assign serve       = r_serve;
    assign game_over   = r_game_over;
    assign state_code  = r_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios with literal expectations, then random play,
// all checked every frame against a frame-level behavioural model of the game rules.
module tb_game_flow_ctrl;

    localparam int START_LIVES  = 3;
    localparam int SERVE_FRAMES = 90;
    localparam int LEVEL_FRAMES = 120;
    localparam int MAX_LEVEL    = 4;
    localparam int SCORE_LVL    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_btn = 1'b0;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic [7:0]  score = 8'd0;
    logic        pause, serve, game_over;
    logic [7:0]  lvl_num;
    logic [2:0]  lives;
    logic [15:0] total_score;
    logic [2:0]  state_code;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    game_flow_ctrl dut (
        .frame_clk   (clk),
        .level_rst   (rst),
        .start_btn   (start_btn),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .pause       (pause),
        .lvl_num     (lvl_num),
        .lives       (lives),
        .total_score (total_score),
        .serve       (serve),
        .game_over   (game_over),
        .state_code  (state_code)
    );

    typedef enum int {M_IDLE, M_SERVE, M_PLAY, M_LVL, M_OVER} phase_t;

    phase_t m_st;
    int m_lives, m_lvl, m_total, m_left;
    bit m_serve;
    int p_start, p_miss, p_score;
    bit sr, mr, was_play;

    function automatic int code_of(input phase_t p);
        case (p)
            M_IDLE:  return 0;
            M_SERVE: return 1;
            M_PLAY:  return 2;
            M_LVL:   return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Frame-level model: m_left counts frames still to spend in a timed phase.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = M_IDLE; m_lives = START_LIVES; m_lvl = 1; m_total = 0;
            m_left = 0; m_serve = 0; p_start = 0; p_miss = 0; p_score = 0;
        end else begin
            sr = start_btn && (p_start == 0);
            mr = miss && (p_miss == 0);
            was_play = (m_st == M_PLAY);
            m_serve = 0;
            case (m_st)
                M_IDLE, M_OVER: if (sr) begin
                    m_lives = START_LIVES; m_lvl = 1; m_total = 0;
                    m_left = SERVE_FRAMES; m_st = M_SERVE;
                end
                M_SERVE: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_st = M_PLAY; m_serve = 1; end
                end
                M_PLAY: begin
                    if (int'(score) == (p_score + 1) % 256)
                        m_total = (m_total < 65535) ? m_total + 1 : 65535;
                    if (mr) begin
                        m_lives = m_lives - 1;
                        if (m_lives == 0) m_st = M_OVER;
                        else begin m_st = M_SERVE; m_left = SERVE_FRAMES; end
                    end else if (int'(score) >= SCORE_LVL) begin
                        m_st = M_LVL; m_left = LEVEL_FRAMES;
                    end
                end
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_lvl = (m_lvl < MAX_LEVEL) ? m_lvl + 1 : MAX_LEVEL;
                        m_st = M_SERVE; m_left = SERVE_FRAMES;
                    end
                end
            endcase
            p_start = start_btn;
            p_miss  = miss;
            p_score = was_play ? int'(score) : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state_code", int'(state_code), code_of(m_st));
            check("pause", int'(pause), (m_st != M_PLAY) ? 1 : 0);
            check("game_over", int'(game_over), (m_st == M_OVER) ? 1 : 0);
            check("serve", int'(serve), int'(m_serve));
            check("lvl_num", int'(lvl_num), m_lvl);
            check("lives", int'(lives), m_lives);
            check("total_score", int'(total_score), m_total);
        end
    end

    task automatic cyc(input bit st, input bit ms, input int sc);
        @(negedge clk);
        start_btn = st;
        miss      = ms;
        score     = 8'(sc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_frames(input int n);
        repeat (n) cyc(1'b0, 1'b0, 0);
    endtask

    task automatic climb();
        for (int s = 1; s <= SCORE_LVL; s++) cyc(1'b0, 1'b0, s);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mhold;
        int sc;
        #1 rst = 1'b1;
        #21 rst = 1'b0;
        chk_en = 1'b1;
        check("rst_state", int'(state_code), 0);
        check("rst_pause", int'(pause), 1);
        check("rst_lives", int'(lives), 3);
        check("rst_lvl", int'(lvl_num), 1);

        // start -> SERVE, 90 frames, one-frame serve pulse into PLAY
        cyc(1'b1, 1'b0, 0);
        check("start_serve", int'(state_code), 1);
        check("start_lives", int'(lives), 3);
        idle_frames(89);
        check("serve_hold", int'(state_code), 1);
        cyc(1'b0, 1'b0, 0);
        check("play_entry", int'(state_code), 2);
        check("serve_pulse", int'(serve), 1);
        check("play_pause", int'(pause), 0);
        cyc(1'b0, 1'b0, 0);
        check("serve_drop", int'(serve), 0);

        // score ramp -> LEVEL_UP, then 120 + 90 frames to level 2 play
        climb();
        check("ramp_total", int'(total_score), 5);
        check("ramp_lvlup", int'(state_code), 3);
        idle_frames(119);
        check("lvlup_hold", int'(state_code), 3);
        cyc(1'b0, 1'b0, 0);
        check("lvl2_serve", int'(state_code), 1);
        check("lvl2", int'(lvl_num), 2);
        idle_frames(90);
        check("lvl2_play", int'(state_code), 2);

        // miss and threshold together: miss wins
        cyc(1'b0, 1'b1, 5);
        check("tie_state", int'(state_code), 1);
        check("tie_lives", int'(lives), 2);
        check("tie_lvl", int'(lvl_num), 2);
        repeat (4) cyc(1'b0, 1'b1, 0);
        idle_frames(86);
        check("tie_play", int'(state_code), 2);

        // held miss counts once; last life -> GAME_OVER
        repeat (5) cyc(1'b0, 1'b1, 0);
        check("miss_once", int'(lives), 1);
        idle_frames(86);
        cyc(1'b0, 1'b1, 0);
        check("over_lives", int'(lives), 0);
        check("over_flag", int'(game_over), 1);
        idle_frames(3);
        check("over_hold", int'(state_code), 4);

        // restart from GAME_OVER
        cyc(1'b1, 1'b0, 0);
        check("restart_state", int'(state_code), 1);
        check("restart_lives", int'(lives), 3);
        check("restart_total", int'(total_score), 0);
        idle_frames(90);

        // climb to MAX_LEVEL and past it
        repeat (3) begin climb(); idle_frames(210); end
        check("lvl4", int'(lvl_num), 4);
        check("lvl4_total", int'(total_score), 15);
        climb();
        idle_frames(210);
        check("lvl_sat", int'(lvl_num), 4);
        check("lvl_sat_state", int'(state_code), 2);

        // asynchronous reset mid LEVEL_UP
        climb();
        idle_frames(69);
        check("pre_rst_state", int'(state_code), 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", int'(state_code), 0);
        check("arst_lvl", int'(lvl_num), 1);
        check("arst_total", int'(total_score), 0);
        check("arst_lives", int'(lives), 3);
        @(negedge clk);
        #2 rst = 1'b0;
        idle_frames(3);
        check("post_rst_idle", int'(state_code), 0);

        // random play
        mhold = 0;
        sc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start_btn = ($urandom_range(0, 24) == 0);
            hit = 1'($urandom_range(0, 1));
            if (mhold > 0) begin
                miss = 1'b1; mhold--;
            end else if ($urandom_range(0, 59) == 0) begin
                miss = 1'b1; mhold = $urandom_range(0, 5);
            end else begin
                miss = 1'b0;
            end
            if (m_st != M_PLAY) sc = 0;
            else if ($urandom_range(0, 3) == 0) sc = sc + 1;
            else if ($urandom_range(0, 29) == 0) sc = $urandom_range(0, 9);
            score = 8'(sc);
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst = 1'b1;
                #6 rst = 1'b0;
            end
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
